// File: rtl/regfile_scoreboard_pkg.sv
// rf_pkg: shared defaults, address/counter types and helpers for regfile_scoreboard.
package rf_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREG_DEF   = 32;
    localparam int PEND_W_DEF = 2;

    // Never returns 0 so that a degenerate register count still yields a usable address width.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [clog2_safe(NREG_DEF)-1:0] reg_addr_t;
    typedef logic [PEND_W_DEF-1:0]           pend_cnt_t;

    localparam pend_cnt_t PEND_MAX = '1;

endpackage

// File: rtl/regfile_scoreboard_pend_counter.sv
// rf_pend_counter: one register's saturating pending-write counter.
//   clk_i/rst_i   clock, async active-high reset
//   inc_i         one accepted issue this cycle
//   dec_i         0..2 completions (writeback and/or kill) this cycle
//   cnt_o         registered count
//   at_max_o      count saturated
//   nonzero_o     count nonzero
//   underflow_o   this cycle asks for more decrements than available (count clamps to 0)
module rf_pend_counter #(
    parameter int PEND_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inc_i,
    input  logic [1:0]        dec_i,
    output logic [PEND_W-1:0] cnt_o,
    output logic              at_max_o,
    output logic              nonzero_o,
    output logic              underflow_o
);

    logic [PEND_W-1:0] cnt_q, cnt_d;
    logic [PEND_W:0]   sum;

    // One extra bit so that max + inc cannot wrap before the decrement is applied.
    always_comb begin
        sum         = {1'b0, cnt_q} + (PEND_W+1)'(inc_i);
        underflow_o = sum < (PEND_W+1)'(dec_i);
        cnt_d       = underflow_o ? '0 : PEND_W'(sum - (PEND_W+1)'(dec_i));
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;

    assign cnt_o     = cnt_q;
    assign at_max_o  = &cnt_q;
    assign nonzero_o = |cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with write-through bypass and per-register pending-write scoreboard.
//   HCLK/HRESET          clock, async active-high reset
//   rd_addr/rd_data      NUM_RD packed combinational read ports (bypassed from writeback)
//   rd_busy              per port: operand still has an unsatisfied outstanding write
//   iss_en/iss_rd        decode issues a writer; iss_ready low when that counter is saturated
//   wb_en/wb_addr/wb_data writeback (writes register, retires one pending write)
//   kill_en/kill_addr    squashed writer (retires one pending write, no data)
//   busy_any             some register has pending writes
//   err_underflow        sticky: a retire hit an empty counter
//   RF_DBG_PORT_EN adds dbg_addr/dbg_data/dbg_pend for unbypassed register and counter inspection.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int AW     = clog2_safe(NREG),
    parameter int NUM_RD = 2,
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_rd,
    output logic                   iss_ready,
    input  logic                   wb_en,
    input  logic [AW-1:0]          wb_addr,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   kill_en,
    input  logic [AW-1:0]          kill_addr,
`ifdef RF_DBG_PORT_EN
    input  logic [AW-1:0]          dbg_addr,
    output logic [XLEN-1:0]        dbg_data,
    output logic [PEND_W-1:0]      dbg_pend,
`endif
    output logic                   busy_any,
    output logic                   err_underflow
);

    logic [XLEN-1:0]   reg_q [NREG];
    logic [PEND_W-1:0] cnt   [NREG];
    logic [NREG-1:0]   at_max, nonzero, uf;
    logic              err_q, err_d, iss_dec;

    always_ff @(posedge HCLK or posedge HRESET)
        if (HRESET) for (int r = 0; r < NREG; r++) reg_q[r] <= '0;
        else if (wb_en && wb_addr != '0) reg_q[wb_addr] <= wb_data;

    // x0 has no counter: it is never busy and never blocks issue.
    assign cnt[0]     = '0;
    assign at_max[0]  = 1'b0;
    assign nonzero[0] = 1'b0;
    assign uf[0]      = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        logic       inc;
        logic [1:0] dec;
        assign inc = iss_en && iss_ready && iss_rd == AW'(r);
        assign dec = {1'b0, wb_en && wb_addr == AW'(r)} + {1'b0, kill_en && kill_addr == AW'(r)};
        rf_pend_counter #(.PEND_W(PEND_W)) u_cnt (
            .clk_i       (HCLK),
            .rst_i       (HRESET),
            .inc_i       (inc),
            .dec_i       (dec),
            .cnt_o       (cnt[r]),
            .at_max_o    (at_max[r]),
            .nonzero_o   (nonzero[r]),
            .underflow_o (uf[r])
        );
    end

    // A same-cycle writeback or kill frees a slot, so a saturated counter can still accept.
    assign iss_dec   = (wb_en && wb_addr == iss_rd) || (kill_en && kill_addr == iss_rd);
    assign iss_ready = !(iss_rd != '0 && at_max[iss_rd] && !iss_dec);

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        assign a   = rd_addr[i*AW +: AW];
        assign hit = wb_en && wb_addr == a;
        assign rd_data[i*XLEN +: XLEN] = (a == '0) ? '0 : hit ? wb_data : reg_q[a];
        // cnt - hit != 0 without a subtractor; kill deliberately does not clear busy this cycle.
        assign rd_busy[i] = (a != '0) && (cnt[a] != PEND_W'(hit));
    end

    assign err_d = err_q | (|uf);

    always_ff @(posedge HCLK or posedge HRESET)
        if (HRESET) err_q <= 1'b0;
        else        err_q <= err_d;

    assign busy_any      = |nonzero;
    assign err_underflow = err_q;

`ifdef RF_DBG_PORT_EN
    assign dbg_data = (dbg_addr == '0) ? '0 : reg_q[dbg_addr];
    assign dbg_pend = cnt[dbg_addr];
`endif

endmodule
